// File: rtl/spi_cmd_pkg.sv
// Shared constants for the SPI command controller: opcodes, FSM state encoding
// and the bit positions of the status byte returned by a STATUS read.
package spi_cmd_pkg;

  localparam logic [2:0] OP_WR_DIVR = 3'b001;
  localparam logic [2:0] OP_WR_DIVF = 3'b010;
  localparam logic [2:0] OP_STREAM  = 3'b011;
  localparam logic [2:0] OP_STATUS  = 3'b100;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    WR_DIVR = 3'd2,
    WR_DIVF = 3'd3,
    STREAM  = 3'd4,
    STATUS  = 3'd5,
    DRAIN   = 3'd6
  } state_t;

  localparam int STAT_FULL_BIT  = 7;
  localparam int STAT_EMPTY_BIT = 6;
  localparam int STAT_OVF_BIT   = 5;

endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// Pin bundle between the SPI command controller and its environment
// (SPI host pins, TX FIFO side, frequency-synth divider registers).
interface spi_cmd_ctrl_if
  import spi_cmd_pkg::*;
#(
  parameter int CH_W       = 2,
  parameter int FIFO_CNT_W = 12
);
  logic                  SCK;
  logic                  MOSI;
  logic                  SSEL;
  logic                  MISO;
  logic [FIFO_CNT_W-1:0] fifo_space_free;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [7:0]            fifo_data_in;
  logic                  fifo_wr;
  logic [7:0]            freq_data;
  logic [CH_W-1:0]       freq_ch;
  logic                  freq_wr_divr;
  logic                  freq_wr_divf;
  logic                  busy;
  state_t                dbg_state;

  // fifo_wr, freq_wr_divr and freq_wr_divf are one-clk strobes with no
  // back-pressure: the data beside each strobe is valid in the strobe cycle
  // and the receiver must accept it then.
  modport slave (
    input  SCK, MOSI, SSEL, fifo_space_free, fifo_empty, fifo_full,
    output MISO, fifo_data_in, fifo_wr, freq_data, freq_ch,
           freq_wr_divr, freq_wr_divf, busy, dbg_state
  );

  modport master (
    output SCK, MOSI, SSEL, fifo_space_free, fifo_empty, fifo_full,
    input  MISO, fifo_data_in, fifo_wr, freq_data, freq_ch,
           freq_wr_divr, freq_wr_divf, busy, dbg_state
  );
endinterface

// File: rtl/spi_byte_if.sv
// SPI mode-0 byte engine: pin synchronisers, SCK edge detect, bit counter,
// MOSI shift-in with a one-clk byte strobe, and the MISO shift-out register.
module spi_byte_if #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       mosi,
  input  logic       ssel,
  input  logic [7:0] tx_next,
  output logic [7:0] rx_byte,
  output logic       byte_stb,
  output logic       ssel_s,
  output logic       ssel_fall,
  output logic       miso
);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] ssel_sync;
  logic                   sck_q;
  logic                   ssel_q;
  logic                   sck_s;
  logic                   mosi_s;
  logic                   sck_rise;
  logic                   sck_fall;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx_shift;
  logic [7:0]             tx_shift;

  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ssel_s    = ssel_sync[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_q;
  assign sck_fall  = ~sck_s & sck_q;
  assign ssel_fall = ssel_q & ~ssel_s;
  assign miso      = tx_shift[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      ssel_sync <= '0;
      sck_q     <= 1'b0;
      ssel_q    <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], ssel};
      sck_q     <= sck_s;
      ssel_q    <= ssel_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 8'h00;
      rx_byte  <= 8'h00;
      byte_stb <= 1'b0;
      tx_shift <= 8'h00;
    end else if (ssel_s) begin
      // Deselect throws away any partial byte in both directions.
      bit_cnt  <= 3'd0;
      rx_shift <= 8'h00;
      byte_stb <= 1'b0;
      tx_shift <= 8'h00;
    end else begin
      byte_stb <= 1'b0;
      if (sck_rise) begin
        rx_shift <= {rx_shift[6:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte  <= {rx_shift[6:0], mosi_s};
          byte_stb <= 1'b1;
        end
      end
      // The falling edge after the 8th rise is the byte boundary: the next
      // tx byte is already loaded and its MSB must stay on the pin.
      if (byte_stb) begin
        tx_shift <= tx_next;
      end else if (sck_fall && bit_cnt != 3'd0) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI-slave command controller: decodes divider writes, FIFO streaming and
// status readback. Optional sticky overflow flag: define SPI_OVF_FLAG_EN.
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int FIFO_CNT_W  = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  spi_cmd_ctrl_if.slave  bus
);

  state_t          state;
  state_t          state_n;
  logic [7:0]      rx_byte;
  logic [7:0]      tx_next;
  logic            byte_stb;
  logic            ssel_s;
  logic            ssel_fall;
  logic [2:0]      opcode;
  logic            ch_ok;
  logic [CH_W-1:0] cmd_ch;
  logic [1:0]      stat_idx;
  logic [15:0]     space16;
  logic [15:0]     space_snap;
  logic [7:0]      status_byte;
  logic            ovf;
  logic            do_divr;
  logic            do_divf;
  logic            do_wr;
  logic            load_cmd;
  logic            take_snap;

  spi_byte_if #(.SYNC_STAGES(SYNC_STAGES)) u_byte (
    .clk       (clk),
    .rst_n     (rst),
    .sck       (bus.SCK),
    .mosi      (bus.MOSI),
    .ssel      (bus.SSEL),
    .tx_next   (tx_next),
    .rx_byte   (rx_byte),
    .byte_stb  (byte_stb),
    .ssel_s    (ssel_s),
    .ssel_fall (ssel_fall),
    .miso      (bus.MISO)
  );

  assign opcode = rx_byte[7:5];
  assign ch_ok  = (int'(rx_byte[4:0]) < NUM_CH);

  generate
    if (FIFO_CNT_W >= 16) begin : g_space_trunc
      assign space16 = bus.fifo_space_free[15:0];
    end else begin : g_space_ext
      assign space16 = {{(16-FIFO_CNT_W){1'b0}}, bus.fifo_space_free};
    end
  endgenerate

`ifdef SPI_OVF_FLAG_EN
  // Sticky until a STATUS transaction has been read out and closed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (state == STREAM && byte_stb && bus.fifo_full) begin
      ovf <= 1'b1;
    end else if (state == STATUS && ssel_s) begin
      ovf <= 1'b0;
    end
  end
`else
  assign ovf = 1'b0;
`endif

  always_comb begin
    status_byte                 = 8'h00;
    status_byte[STAT_FULL_BIT]  = bus.fifo_full;
    status_byte[STAT_EMPTY_BIT] = bus.fifo_empty;
    status_byte[STAT_OVF_BIT]   = ovf;
  end

  always_comb begin
    state_n   = state;
    tx_next   = 8'h00;
    do_divr   = 1'b0;
    do_divf   = 1'b0;
    do_wr     = 1'b0;
    load_cmd  = 1'b0;
    take_snap = 1'b0;
    case (state)
      IDLE: if (ssel_fall) state_n = CMD;
      CMD: begin
        if (byte_stb) begin
          load_cmd = 1'b1;
          case (opcode)
            OP_WR_DIVR: state_n = ch_ok ? WR_DIVR : DRAIN;
            OP_WR_DIVF: state_n = ch_ok ? WR_DIVF : DRAIN;
            OP_STREAM:  state_n = STREAM;
            OP_STATUS: begin
              state_n   = STATUS;
              tx_next   = status_byte;
              take_snap = 1'b1;
            end
            default:    state_n = DRAIN;
          endcase
        end
      end
      WR_DIVR: begin
        if (byte_stb) begin
          do_divr = 1'b1;
          state_n = DRAIN;
        end
      end
      WR_DIVF: begin
        if (byte_stb) begin
          do_divf = 1'b1;
          state_n = DRAIN;
        end
      end
      STREAM: if (byte_stb) do_wr = ~bus.fifo_full;
      STATUS: begin
        if (byte_stb) begin
          case (stat_idx)
            2'd0:    tx_next = space_snap[15:8];
            2'd1:    tx_next = space_snap[7:0];
            default: tx_next = 8'h00;
          endcase
        end
      end
      default: ;
    endcase
    // A byte completing in the deselect cycle is still acted on above.
    if (ssel_s) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      cmd_ch           <= '0;
      stat_idx         <= 2'd0;
      space_snap       <= 16'h0000;
      bus.fifo_data_in <= 8'h00;
      bus.fifo_wr      <= 1'b0;
      bus.freq_data    <= 8'h00;
      bus.freq_ch      <= '0;
      bus.freq_wr_divr <= 1'b0;
      bus.freq_wr_divf <= 1'b0;
    end else begin
      state            <= state_n;
      bus.fifo_wr      <= do_wr;
      bus.freq_wr_divr <= do_divr;
      bus.freq_wr_divf <= do_divf;
      if (do_wr) bus.fifo_data_in <= rx_byte;
      if (do_divr || do_divf) begin
        bus.freq_data <= rx_byte;
        bus.freq_ch   <= cmd_ch;
      end
      if (load_cmd)  cmd_ch     <= rx_byte[CH_W-1:0];
      if (take_snap) space_snap <= space16;
      if (state == CMD) begin
        stat_idx <= 2'd0;
      end else if (state == STATUS && byte_stb && stat_idx != 2'd3) begin
        stat_idx <= stat_idx + 2'd1;
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.dbg_state = state;

endmodule
